// File: rtl/mips_multi_ctrl_pkg.sv
// Shared constants, state type and per-state control word for the multicycle MIPS controller.
package mips_multi_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALU control encodings
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  // ALU source B select
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11,
    StHalt    = 4'd12
  } state_t;

  // Control word held in the output register; pc_write/branch are combined with zero later.
  typedef struct packed {
    logic       ior_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       instr_done;
    logic       halted;
  } ctrl_t;

  // Moore output decode; ex_alu is the funct-decoded ALU op, only used in EXECUTE.
  function automatic ctrl_t state_ctrl(state_t s, logic [2:0] ex_alu);
    ctrl_t c;
    c          = '0;
    c.alu_ctrl = AluAdd;
    case (s)
      StFetch: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = SrcBFour;
        c.pc_src    = PcSrcAlu;
        c.pc_write  = 1'b1;
      end
      StDecode: begin
        c.alu_src_b = SrcBImmSh;
      end
      StMemAdr: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBImm;
      end
      StMemRd: begin
        c.ior_d = 1'b1;
      end
      StMemWb: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      StMemWr: begin
        c.ior_d      = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      StExecute: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBReg;
        c.alu_ctrl  = ex_alu;
      end
      StAluWb: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      StBranch: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SrcBReg;
        c.alu_ctrl   = AluSub;
        c.branch     = 1'b1;
        c.pc_src     = PcSrcAluOut;
        c.instr_done = 1'b1;
      end
      StAddiEx: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SrcBImm;
      end
      StAddiWb: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      StJump: begin
        c.pc_src     = PcSrcJump;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
      end
      StHalt: begin
        c.halted = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_multi_ctrl_if.sv
// Controller <-> datapath signal bundle: IR fields and flags in, selects and enables out.
interface mips_multi_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       ior_d;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       instr_done;
  logic       halted;

  // Controller side
  modport master (
    input  opcode, funct, zero,
    output ior_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en, instr_done, halted
  );

  // Datapath side
  modport slave (
    output opcode, funct, zero,
    input  ior_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
    input  alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en, instr_done, halted
  );
endinterface

// File: rtl/mips_multi_ctrl_aludec.sv
// Combinational R-type funct -> ALU control decoder; unknown functs fall back to add.
module mips_multi_ctrl_aludec
  import mips_multi_ctrl_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_ctrl
);

  // funct lookup
  always_comb begin
    o_alu_ctrl = AluAdd;
    case (i_funct)
      FnAdd:   o_alu_ctrl = AluAdd;
      FnSub:   o_alu_ctrl = AluSub;
      FnAnd:   o_alu_ctrl = AluAnd;
      FnOr:    o_alu_ctrl = AluOr;
      FnSlt:   o_alu_ctrl = AluSlt;
      default: o_alu_ctrl = AluAdd;
    endcase
  end

endmodule

// File: rtl/mips_multi_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath.
// The control word is registered from the next state, so it lines up with the state register
// exactly as a Moore decode would, without a combinational decode path after the flops.
module mips_multi_ctrl
  import mips_multi_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input logic              i_clk,
  input logic              i_reset,
  mips_multi_ctrl_if.master bus
);

  state_t     r_state;
  state_t     w_state_next;
  ctrl_t      r_ctrl;
  logic [2:0] w_ex_alu;

  mips_multi_ctrl_aludec u_aludec (
    .i_funct    (bus.funct),
    .o_alu_ctrl (w_ex_alu)
  );

  // Next-state selection; funct/opcode are stable from DECODE, so decoding ahead is safe.
  always_comb begin
    w_state_next = StFetch;
    case (r_state)
      StFetch:  w_state_next = StDecode;
      StDecode: begin
        case (bus.opcode)
          OpLw, OpSw: w_state_next = StMemAdr;
          OpRtype:    w_state_next = StExecute;
          OpBeq:      w_state_next = StBranch;
          OpAddi:     w_state_next = StAddiEx;
          OpJ:        w_state_next = StJump;
          default:    w_state_next = ILLEGAL_TRAP ? StHalt : StFetch;
        endcase
      end
      StMemAdr:  w_state_next = (bus.opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:   w_state_next = StMemWb;
      StExecute: w_state_next = StAluWb;
      StAddiEx:  w_state_next = StAddiWb;
      StHalt:    w_state_next = StHalt;
      // Final states and any unused encoding return to FETCH.
      default:   w_state_next = StFetch;
    endcase
  end

  // State and registered control word, synchronous active-high reset to FETCH
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StFetch;
      r_ctrl  <= state_ctrl(StFetch, w_ex_alu);
    end else begin
      r_state <= w_state_next;
      r_ctrl  <= state_ctrl(w_state_next, w_ex_alu);
    end
  end

  // Selects pass straight through; enables are gated off while reset is high.
  always_comb begin
    bus.ior_d      = r_ctrl.ior_d;
    bus.reg_dst    = r_ctrl.reg_dst;
    bus.mem_to_reg = r_ctrl.mem_to_reg;
    bus.alu_src_a  = r_ctrl.alu_src_a;
    bus.alu_src_b  = r_ctrl.alu_src_b;
    bus.alu_ctrl   = r_ctrl.alu_ctrl;
    bus.pc_src     = r_ctrl.pc_src;
    bus.halted     = r_ctrl.halted;
    bus.mem_write  = r_ctrl.mem_write & ~i_reset;
    bus.ir_write   = r_ctrl.ir_write & ~i_reset;
    bus.reg_write  = r_ctrl.reg_write & ~i_reset;
    bus.instr_done = r_ctrl.instr_done & ~i_reset;
    bus.pc_en      = ~i_reset & (r_ctrl.pc_write | (r_ctrl.branch & bus.zero));
  end

endmodule
